// File: rtl/id_ex_stage.sv
// ID/EX operand stage: register-file read, operand forwarding, load-use stall and ID/EX pipeline register.
// Define ID_FWD_EN to enable forwarding; without it, every RAW hazard against EX, EX/MEM or MEM/WB stalls.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_wr,
  input  logic              id_mem_rd,
  output logic [4:0]        rf_r1_addr,
  output logic [4:0]        rf_r2_addr,
  input  logic [31:0]       rf_r1_dout,
  input  logic [31:0]       rf_r2_dout,
  input  logic [31:0]       ex_alu_res,
  input  logic              exmem_wr,
  input  logic [4:0]        exmem_addr,
  input  logic [31:0]       exmem_data,
  input  logic              memwb_wr,
  input  logic [4:0]        memwb_addr,
  input  logic [31:0]       memwb_data,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [31:0]       ex_a,
  output logic [31:0]       ex_b,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_wr,
  output logic              ex_mem_rd
);

  logic              valid_q, valid_d;
  logic [31:0]       a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [4:0]        rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              reg_wr_q, reg_wr_d, mem_rd_q, mem_rd_d;
  logic [31:0]       op_a, op_b;
  logic              lu;

  assign rf_r1_addr = id_rs;
  assign rf_r2_addr = id_rt;

`ifdef ID_FWD_EN
  // Youngest producer wins; the RF read port does not yet see the MEM/WB write.
  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == '0)                                        return '0;
    else if (valid_q && reg_wr_q && !mem_rd_q && rd_q == r) return ex_alu_res;
    else if (exmem_wr && exmem_addr == r)               return exmem_data;
    else if (memwb_wr && memwb_addr == r)               return memwb_data;
    else                                                return rf;
  endfunction

  always_comb begin
    op_a = fwd(id_rs, rf_r1_dout);
    op_b = fwd(id_rt, rf_r2_dout);
    lu   = !rst && id_valid && valid_q && mem_rd_q && (rd_q != '0) &&
           ((rd_q == id_rs) || (rd_q == id_rt));
  end
`else
  function automatic logic raw(input logic [4:0] r);
    return (r != '0) && ((valid_q && reg_wr_q && rd_q == r) ||
                         (exmem_wr && exmem_addr == r) ||
                         (memwb_wr && memwb_addr == r));
  endfunction

  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_alu_res, exmem_data, memwb_data};

  always_comb begin
    op_a = (id_rs == '0) ? '0 : rf_r1_dout;
    op_b = (id_rt == '0) ? '0 : rf_r2_dout;
    lu   = !rst && id_valid && (raw(id_rs) || raw(id_rt));
  end
`endif

  assign stall_out = ex_hold || (lu && !flush);

  always_comb begin
    valid_d  = valid_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;
    reg_wr_d = reg_wr_q;
    mem_rd_d = mem_rd_q;
    if (!ex_hold) begin
      if (flush || lu || !id_valid) begin
        valid_d  = 1'b0;
        a_d      = '0;
        b_d      = '0;
        imm_d    = '0;
        rd_d     = '0;
        ctrl_d   = '0;
        reg_wr_d = 1'b0;
        mem_rd_d = 1'b0;
      end else begin
        valid_d  = 1'b1;
        a_d      = op_a;
        b_d      = op_b;
        imm_d    = id_imm;
        rd_d     = id_rd;
        ctrl_d   = id_ctrl;
        reg_wr_d = id_reg_wr;
        mem_rd_d = id_mem_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      reg_wr_q <= 1'b0;
      mem_rd_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      a_q      <= a_d;
      b_q      <= b_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      reg_wr_q <= reg_wr_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_a      = a_q;
  assign ex_b      = b_q;
  assign ex_imm    = imm_q;
  assign ex_rd     = rd_q;
  assign ex_ctrl   = ctrl_q;
  assign ex_reg_wr = reg_wr_q;
  assign ex_mem_rd = mem_rd_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; covers the build selected by ID_FWD_EN.
module tb_id_ex_stage;
  localparam int unsigned CTRL_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [31:0]       id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              id_reg_wr, id_mem_rd;
  logic [4:0]        rf_r1_addr, rf_r2_addr;
  logic [31:0]       rf_r1_dout, rf_r2_dout, ex_alu_res;
  logic              exmem_wr;
  logic [4:0]        exmem_addr;
  logic [31:0]       exmem_data;
  logic              memwb_wr;
  logic [4:0]        memwb_addr;
  logic [31:0]       memwb_data;
  logic              flush, ex_hold, stall_out;
  logic              ex_valid;
  logic [31:0]       ex_a, ex_b, ex_imm;
  logic [4:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_reg_wr, ex_mem_rd;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
    .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr), .rf_r1_dout(rf_r1_dout), .rf_r2_dout(rf_r2_dout),
    .ex_alu_res(ex_alu_res), .exmem_wr(exmem_wr), .exmem_addr(exmem_addr), .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_addr(memwb_addr), .memwb_data(memwb_data),
    .flush(flush), .ex_hold(ex_hold), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic wr, input logic ld);
    id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_reg_wr = wr; id_mem_rd = ld;
  endtask

  task automatic bubble();
    id_valid = 1'b0; exmem_wr = 1'b0; memwb_wr = 1'b0; flush = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_imm = 0; id_ctrl = 0;
    id_reg_wr = 0; id_mem_rd = 0; rf_r1_dout = 0; rf_r2_dout = 0; ex_alu_res = 0;
    exmem_wr = 0; exmem_addr = 0; exmem_data = 0; memwb_wr = 0; memwb_addr = 0; memwb_data = 0;
    flush = 0; ex_hold = 0;
    tick(); tick();
    check("reset_valid", {31'b0, ex_valid}, 32'h0);
    check("reset_stall", {31'b0, stall_out}, 32'h0);
    rst = 1'b0;

    // First instruction, then async reset mid-run
    instr(5'd3, 5'd0, 5'd6, 1'b1, 1'b0);
    id_imm = 32'h0000_1234; id_ctrl = 16'hBEEF; rf_r1_dout = 32'h11; rf_r2_dout = 32'h99;
    settle();
    check("rf_addr", {22'b0, rf_r1_addr, rf_r2_addr}, {22'b0, 5'd3, 5'd0});
    tick();
    check("first_valid", {31'b0, ex_valid}, 32'h1);
    check("first_a", ex_a, 32'h11);
    check("first_b_r0", ex_b, 32'h0);
    check("first_imm", ex_imm, 32'h1234);
    check("first_rd_ctrl", {11'b0, ex_rd, ex_ctrl}, {11'b0, 5'd6, 16'hBEEF});
    check("first_flags", {30'b0, ex_reg_wr, ex_mem_rd}, 32'h2);
    #2 rst = 1'b1;
    settle();
    check("async_rst_valid", {31'b0, ex_valid}, 32'h0);
    check("async_rst_a", ex_a, 32'h0);
    check("async_rst_misc", {ex_ctrl, 11'b0, ex_rd}, 32'h0);
    check("async_rst_imm", ex_imm, 32'h0);
    ex_hold = 1'b1; settle();
    check("rst_stall_hold", {31'b0, stall_out}, 32'h1);
    ex_hold = 1'b0; settle();
    check("rst_stall_nohold", {31'b0, stall_out}, 32'h0);
    tick();
    rst = 1'b0;
    id_reg_wr = 1'b0;
    tick();
    check("post_rst_a", ex_a, 32'h11);
    check("post_rst_valid", {31'b0, ex_valid}, 32'h1);
    bubble();
    check("bubble_valid", {31'b0, ex_valid}, 32'h0);

`ifdef ID_FWD_EN
    // EX forwarding
    instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0); tick();
    instr(5'd5, 5'd0, 5'd5, 1'b1, 1'b0); rf_r1_dout = 32'h0; ex_alu_res = 32'hAAAA_0001;
    settle();
    check("exfwd_stall", {31'b0, stall_out}, 32'h0);
    tick();
    check("exfwd_a", ex_a, 32'hAAAA_0001);
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); rf_r1_dout = 32'h77; tick();
    check("exfwd_r0", ex_a, 32'h0);

    // EX/MEM over MEM/WB priority
    exmem_wr = 1; exmem_addr = 5'd7; exmem_data = 32'h22;
    memwb_wr = 1; memwb_addr = 5'd7; memwb_data = 32'h33;
    instr(5'd0, 5'd7, 5'd0, 1'b0, 1'b0); rf_r2_dout = 32'h44; tick();
    check("prio_exmem", ex_b, 32'h22);
    exmem_wr = 0; tick();
    check("prio_memwb", ex_b, 32'h33);
    memwb_wr = 0; tick();
    check("prio_rf", ex_b, 32'h44);
    bubble();

    // Load-use: one bubble, then forward from EX/MEM
    instr(5'd0, 5'd0, 5'd4, 1'b1, 1'b1); tick();
    instr(5'd0, 5'd4, 5'd8, 1'b0, 1'b0); rf_r2_dout = 32'h0; settle();
    check("lu_stall", {31'b0, stall_out}, 32'h1);
    tick();
    check("lu_bubble", {29'b0, ex_valid, ex_reg_wr, ex_mem_rd}, 32'h0);
    exmem_wr = 1; exmem_addr = 5'd4; exmem_data = 32'h5A; settle();
    check("lu_release", {31'b0, stall_out}, 32'h0);
    tick();
    check("lu_fwd_b", ex_b, 32'h5A);
    check("lu_fwd_valid", {31'b0, ex_valid}, 32'h1);
    bubble();

    // Load into r0 never stalls
    instr(5'd0, 5'd0, 5'd0, 1'b1, 1'b1); tick();
    instr(5'd0, 5'd0, 5'd8, 1'b0, 1'b0); settle();
    check("lu_r0", {31'b0, stall_out}, 32'h0);
    bubble();

    // Flush beats load-use
    instr(5'd0, 5'd0, 5'd4, 1'b1, 1'b1); tick();
    instr(5'd4, 5'd0, 5'd8, 1'b1, 1'b0); flush = 1; settle();
    check("flush_stall", {31'b0, stall_out}, 32'h0);
    tick();
    check("flush_bubble", {29'b0, ex_valid, ex_reg_wr, ex_mem_rd}, 32'h0);
    flush = 0;
    bubble();
`else
    // MEM/WB RAW stalls once, then reads the register file
    memwb_wr = 1; memwb_addr = 5'd9; memwb_data = 32'hDEAD;
    instr(5'd9, 5'd0, 5'd1, 1'b0, 1'b0); rf_r1_dout = 32'h1234; settle();
    check("nf_wb_stall", {31'b0, stall_out}, 32'h1);
    tick();
    check("nf_wb_bubble", {31'b0, ex_valid}, 32'h0);
    memwb_wr = 0; rf_r1_dout = 32'h0000_DEAD; settle();
    check("nf_wb_release", {31'b0, stall_out}, 32'h0);
    tick();
    check("nf_wb_a", ex_a, 32'h0000_DEAD);
    check("nf_wb_valid", {31'b0, ex_valid}, 32'h1);
    bubble();

    // EX/MEM RAW on operand B
    exmem_wr = 1; exmem_addr = 5'd7; exmem_data = 32'h22;
    instr(5'd0, 5'd7, 5'd0, 1'b0, 1'b0); rf_r2_dout = 32'h44; settle();
    check("nf_mem_stall", {31'b0, stall_out}, 32'h1);
    tick();
    exmem_wr = 0; tick();
    check("nf_mem_b", ex_b, 32'h44);
    bubble();

    // EX RAW: no ALU forwarding
    instr(5'd0, 5'd0, 5'd5, 1'b1, 1'b0); tick();
    instr(5'd5, 5'd0, 5'd0, 1'b0, 1'b0); rf_r1_dout = 32'h10; ex_alu_res = 32'hAAAA_0001; settle();
    check("nf_ex_stall", {31'b0, stall_out}, 32'h1);
    tick();
    check("nf_ex_bubble", {31'b0, ex_valid}, 32'h0);
    tick();
    check("nf_ex_a", ex_a, 32'h10);
    bubble();

    // r0 never hazards; id_valid=0 never stalls; flush masks stall
    memwb_wr = 1; memwb_addr = 5'd0;
    instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); rf_r1_dout = 32'h77; settle();
    check("nf_r0_stall", {31'b0, stall_out}, 32'h0);
    tick();
    check("nf_r0_a", ex_a, 32'h0);
    memwb_addr = 5'd9; id_rs = 5'd9; id_valid = 0; settle();
    check("nf_novalid_stall", {31'b0, stall_out}, 32'h0);
    id_valid = 1; flush = 1; settle();
    check("nf_flush_stall", {31'b0, stall_out}, 32'h0);
    tick();
    check("nf_flush_bubble", {31'b0, ex_valid}, 32'h0);
    flush = 0;
    bubble();
`endif

    // Hold freezes ID/EX for 3 cycles and ignores flush
    instr(5'd0, 5'd0, 5'd9, 1'b1, 1'b0); id_imm = 32'h55; id_ctrl = 16'h1234; tick();
    check("hold_pre_imm", ex_imm, 32'h55);
    ex_hold = 1; flush = 1; id_imm = 32'hFFFF; id_rd = 5'd2; id_ctrl = 16'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("hold_stall", {31'b0, stall_out}, 32'h1);
      tick();
      check("hold_imm", ex_imm, 32'h55);
      check("hold_rd_ctrl", {11'b0, ex_rd, ex_ctrl}, {11'b0, 5'd9, 16'h1234});
      check("hold_valid", {30'b0, ex_valid, ex_reg_wr}, 32'h3);
    end
    // Reset during hold clears the register
    rst = 1; settle();
    check("hold_rst_valid", {31'b0, ex_valid}, 32'h0);
    check("hold_rst_imm", ex_imm, 32'h0);
    check("hold_rst_stall", {31'b0, stall_out}, 32'h1);
    tick();
    rst = 0; ex_hold = 0; flush = 0; tick();
    check("after_hold_imm", ex_imm, 32'hFFFF);
    check("after_hold_rd", {27'b0, ex_rd}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
